ddr_axi_bist: RTL and testbench
===============================

// Module: ddr_axi_bist
// PURPOSE
//  Built-in self-test AXI4 master for the DDR3 MIG AXI port (128b data, 32b addr).
//  Sits on the mig_clk side, upstream of the MIG slave and in parallel with the
//  clock-converter output; a mux outside this block selects which master drives it.
//  Writes an address-derived pattern over a region, reads it back, compares, and
//  reports pass/fail, an error count and the first failing address.
// PARAMETERS
//  BASE_ADDR   32'h0000_0000  byte address of first burst; must be 256B aligned
//  NUM_BURSTS  64             bursts per pass, >=1; each 16 beats x 16B = 256B
//  SEED        32'hA5A5_5A5A  XOR key applied to every 32b data lane
// PORTS
//  mig_clk              in   1    sole clock (MIG ui clock)
//  mig_rst              in   1    synchronous, active-high reset
//  init_calib_complete  in   1    MIG calibration done; start ignored while low
//  start                in   1    1-cycle pulse, begins a pass when idle
//  busy                 out  1    high from accepted start until done
//  done                 out  1    sticky, set at end of pass, cleared by next start
//  pass                 out  1    valid when done: error_count==0
//  error_count          out  16   mismatched beats + non-OKAY resp, saturates 16'hFFFF
//  first_err_addr       out  32   byte addr of first bad beat (or burst addr on bad bresp)
//  m_axi                AXI.master (DW=128)  aw*, w*, b*, ar*, r* channels
// BEHAVIOUR
//  - Reset: all outputs 0; awvalid/wvalid/arvalid=0, bready/rready=0; FSM=IDLE.
//  - Fixed fields: awlen/arlen=15, awsize/arsize=3'b100, awburst/arburst=INCR,
//    wstrb=all 1s, id/lock/cache/prot/qos=0.
//  - Burst n addr = BASE_ADDR + n*256 (32b, wraps mod 2^32). Beat k addr A=burst+16k.
//  - Pattern lane i (bits 32i+31:32i) = (A + 4i) ^ SEED, i=0..3.
//  - FSM: IDLE -start&calib-> WR_AW -awready-> WR_D -wlast accepted-> WR_B
//    -bvalid-> (more bursts ? WR_AW : RD_AR) -arready-> RD_D -rlast accepted->
//    (more bursts ? RD_AR : DONE) -> IDLE next cycle.
//  - One burst outstanding at a time; W only after AW handshake; AR after all B.
//  - VALID held stable with payload until READY; never dropped once raised.
//  - bready=1 only in WR_B; rready=1 only in RD_D (no backpressure).
//  - wlast=1 on beat 15 only. Read beat counter 0..15; rlast mismatch with
//    counter ==15 counts one extra error on that beat.
//  - Compare per accepted R beat: rdata!=expected or rresp!=OKAY -> +1 error.
//    bresp!=OKAY -> +1 error. error_count saturates; first_err_addr captured
//    only when error_count was 0.
//  - start in IDLE with calib high: clear done/pass/error_count/first_err_addr,
//    busy=1 next cycle. start while busy or calib low: ignored, no side effects.
//  - DONE: busy=0, done=1, pass=(error_count==0), same cycle.
//  - mig_rst mid-pass: immediate return to reset values (in-flight burst abandoned;
//    MIG is reset by the same signal).
//  - Latency: first awvalid 1 cycle after accepted start.
// TESTING
//  1 BFM slave ideal memory, always ready, NUM_BURSTS=4 -> 4 AW, 64 W, 4 AR,
//    64 R; done=1, pass=1, error_count=0; first W beat = {32'hA5A5_5A5A^{0xC,8,4,0}}.
//  2 Slave corrupts bit 0 of beat at addr 0x120 -> error_count=1,
//    first_err_addr=32'h0000_0120, pass=0.
//  3 Random ready stalls (0-7 cycles) on aw/w/ar -> payload stable while
//    valid&!ready (assertion), same results as test 1.
//  4 bresp=SLVERR on burst 2 -> error_count=1, first_err_addr=32'h0000_0200.
//  5 start with calib=0 -> busy stays 0; start while busy -> no restart.
//  6 mig_rst asserted during WR_D beat 7 -> next cycle all valids 0, busy=0;
//    new start completes with pass=1.

Source files
------------

// File: rtl/ddr_axi_bist_if.sv
// AXI4 bus between the BIST master and the MIG slave port (no response ids).
interface ddr_axi_bist_if #(
  parameter int unsigned DW = 128,
  parameter int unsigned AW = 32,
  parameter int unsigned IW = 4
);
  logic [IW-1:0]   awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic [3:0]      awqos;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [IW-1:0]   arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic [3:0]      arqos;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/ddr_axi_bist.sv
// DDR BIST AXI4 master: writes an address-keyed pattern, reads it back, counts errors.
module ddr_axi_bist #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned NUM_BURSTS = 64,
  parameter logic [31:0] SEED       = 32'hA5A5_5A5A
) (
  input  logic                  mig_clk,
  input  logic                  mig_rst,
  input  logic                  init_calib_complete,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           error_count,
  output logic [31:0]           first_err_addr,
  ddr_axi_bist_if.master        m_axi
);
  localparam int unsigned BCW = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [BCW-1:0] LAST_BURST = BCW'(NUM_BURSTS - 1);
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_AW, S_WR_D, S_WR_B, S_RD_AR, S_RD_D, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [BCW-1:0]  burst_cnt;
  logic [31:0]     burst_addr;
  logic [3:0]      beat_cnt;
  logic [31:0]     beat_addr;
  logic            last_burst;
  logic            w_hs, b_hs, r_hs;
  logic            data_bad, last_bad;
  logic [1:0]      err_inc;
  logic [31:0]     err_addr;
  logic [16:0]     err_sum;
  logic [15:0]     err_next;

  // Data word for one beat: each 32b lane is its own byte address XOR the seed.
  function automatic logic [127:0] pattern(input logic [31:0] a);
    logic [127:0] p;
    for (int i = 0; i < 4; i++) p[32*i +: 32] = (a + 32'(4 * i)) ^ SEED;
    return p;
  endfunction

  assign beat_addr  = burst_addr + {24'd0, beat_cnt, 4'd0};
  assign last_burst = (burst_cnt == LAST_BURST);
  assign w_hs = m_axi.wvalid && m_axi.wready;
  assign b_hs = m_axi.bvalid && m_axi.bready;
  assign r_hs = m_axi.rvalid && m_axi.rready;

  // State register.
  always_ff @(posedge mig_clk) begin
    if (mig_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: one burst in flight, reads start after the last write response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && init_calib_complete) state_d = S_WR_AW;
      S_WR_AW: if (m_axi.awready) state_d = S_WR_D;
      S_WR_D:  if (m_axi.wready && beat_cnt == 4'hF) state_d = S_WR_B;
      S_WR_B:  if (m_axi.bvalid) state_d = last_burst ? S_RD_AR : S_WR_AW;
      S_RD_AR: if (m_axi.arready) state_d = S_RD_D;
      S_RD_D:  if (m_axi.rvalid && m_axi.rlast) state_d = last_burst ? S_DONE : S_RD_AR;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs decoded from state; payloads come from registered counters so they hold while stalled.
  always_comb begin
    m_axi.awvalid = (state_q == S_WR_AW);
    m_axi.wvalid  = (state_q == S_WR_D);
    m_axi.bready  = (state_q == S_WR_B);
    m_axi.arvalid = (state_q == S_RD_AR);
    m_axi.rready  = (state_q == S_RD_D);
    m_axi.awid    = '0;
    m_axi.awaddr  = burst_addr;
    m_axi.awlen   = 8'd15;
    m_axi.awsize  = 3'b100;
    m_axi.awburst = 2'b01;
    m_axi.awlock  = 1'b0;
    m_axi.awcache = 4'd0;
    m_axi.awprot  = 3'd0;
    m_axi.awqos   = 4'd0;
    m_axi.wdata   = pattern(beat_addr);
    m_axi.wstrb   = '1;
    m_axi.wlast   = (beat_cnt == 4'hF);
    m_axi.arid    = '0;
    m_axi.araddr  = burst_addr;
    m_axi.arlen   = 8'd15;
    m_axi.arsize  = 3'b100;
    m_axi.arburst = 2'b01;
    m_axi.arlock  = 1'b0;
    m_axi.arcache = 4'd0;
    m_axi.arprot  = 3'd0;
    m_axi.arqos   = 4'd0;
  end

  // Per-cycle error increment: bad write response, bad read data/resp, misplaced rlast.
  always_comb begin
    data_bad = 1'b0;
    last_bad = 1'b0;
    err_inc  = 2'd0;
    err_addr = beat_addr;
    if (b_hs && m_axi.bresp != RESP_OKAY) begin
      err_inc  = 2'd1;
      err_addr = burst_addr;
    end
    if (r_hs) begin
      data_bad = (m_axi.rdata != pattern(beat_addr)) || (m_axi.rresp != RESP_OKAY);
      last_bad = (m_axi.rlast != (beat_cnt == 4'hF));
      err_inc  = 2'(data_bad) + 2'(last_bad);
    end
    err_sum  = {1'b0, error_count} + 17'(err_inc);
    err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // Counters, address tracking and status registers.
  always_ff @(posedge mig_clk) begin
    if (mig_rst) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      error_count    <= 16'd0;
      first_err_addr <= 32'd0;
      burst_cnt      <= '0;
      burst_addr     <= 32'd0;
      beat_cnt       <= 4'd0;
    end else if (state_q == S_IDLE && start && init_calib_complete) begin
      busy           <= 1'b1;
      done           <= 1'b0;
      pass           <= 1'b0;
      error_count    <= 16'd0;
      first_err_addr <= 32'd0;
      burst_cnt      <= '0;
      burst_addr     <= BASE_ADDR;
      beat_cnt       <= 4'd0;
    end else begin
      error_count <= err_next;
      if (err_inc != 2'd0 && error_count == 16'd0) first_err_addr <= err_addr;
      if (w_hs) beat_cnt <= beat_cnt + 4'd1;
      // rlast realigns the read beat counter even when it arrives out of place
      if (r_hs) beat_cnt <= m_axi.rlast ? 4'd0 : beat_cnt + 4'd1;
      if (b_hs || (r_hs && m_axi.rlast)) begin
        if (last_burst) begin
          burst_cnt  <= '0;
          burst_addr <= BASE_ADDR;
        end else begin
          burst_cnt  <= burst_cnt + BCW'(1);
          burst_addr <= burst_addr + 32'd256;
        end
      end
      if (state_d == S_DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_next == 16'd0);
      end
    end
  end
endmodule

// File: tb/tb_ddr_axi_bist.sv
// Bench for ddr_axi_bist: AXI memory slave at negedge, queue scoreboard for AW/W/AR.
`timescale 1ns/1ps
module tb_ddr_axi_bist;
  localparam int unsigned NB   = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SEED = 32'hA5A5_5A5A;
  localparam logic [127:0] FIRST_BEAT = 128'hA5A55A56_A5A55A52_A5A55A5E_A5A55A5A;

  logic        mig_clk = 1'b0;
  logic        mig_rst, init_calib_complete, start;
  logic        busy, done, pass;
  logic [15:0] error_count;
  logic [31:0] first_err_addr;

  ddr_axi_bist_if #(.DW(128)) axi ();

  ddr_axi_bist #(.BASE_ADDR(BASE), .NUM_BURSTS(NB), .SEED(SEED)) dut (
    .mig_clk(mig_clk), .mig_rst(mig_rst), .init_calib_complete(init_calib_complete),
    .start(start), .busy(busy), .done(done), .pass(pass), .error_count(error_count),
    .first_err_addr(first_err_addr), .m_axi(axi)
  );

  always #5 mig_clk = ~mig_clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
  } wexp_t;

  wexp_t       w_q[$];
  logic [31:0] aw_q[$];
  logic [31:0] ar_q[$];
  logic [127:0] mem [logic [31:0]];

  logic [31:0] corrupt_addr = 32'hFFFF_FFF0;
  int          err_burst = -1;
  bit          stall_en = 1'b0;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int          aw_stall, w_stall, ar_stall;
  bit          b_pend, r_act;
  logic [1:0]  b_resp_pend;
  logic [31:0] w_addr, r_addr, ra, exp_a;
  int          r_beat;
  logic [127:0] rd, first_w;
  wexp_t       we;
  bit          p_awv, p_wv, p_arv;
  logic [31:0] p_awaddr, p_araddr;
  logic [127:0] p_wdata;
  logic        p_wlast;

  function automatic logic [127:0] exp_data(input logic [31:0] a);
    logic [127:0] p;
    for (int i = 0; i < 4; i++) p[32*i +: 32] = (a + 32'(4 * i)) ^ SEED;
    return p;
  endfunction

  // Memory slave; decides ready/valid at negedge, so a handshake computed here is what the next posedge sees.
  always @(negedge mig_clk) begin
    if (mig_rst) begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
      axi.bvalid = 1'b0;  axi.bresp = 2'b00;
      axi.rvalid = 1'b0;  axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rdata = '0;
      b_pend = 1'b0; r_act = 1'b0; p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0;
      aw_stall = 0; w_stall = 0; ar_stall = 0;
    end else begin
      if (p_awv) begin
        n_checks++;
        if (!axi.awvalid || axi.awaddr !== p_awaddr) begin
          n_fail++; $display("FAIL aw_stable: valid=%0b addr=%h, required valid=1 addr=%h", axi.awvalid, axi.awaddr, p_awaddr);
        end
      end
      if (p_wv) begin
        n_checks++;
        if (!axi.wvalid || axi.wdata !== p_wdata || axi.wlast !== p_wlast) begin
          n_fail++; $display("FAIL w_stable: valid=%0b data=%h, required valid=1 data=%h", axi.wvalid, axi.wdata, p_wdata);
        end
      end
      if (p_arv) begin
        n_checks++;
        if (!axi.arvalid || axi.araddr !== p_araddr) begin
          n_fail++; $display("FAIL ar_stable: valid=%0b addr=%h, required valid=1 addr=%h", axi.arvalid, axi.araddr, p_araddr);
        end
      end

      // write response: handled before W so bvalid trails the wlast handshake
      axi.bvalid = b_pend;
      axi.bresp  = b_resp_pend;
      if (b_pend && axi.bready) begin b_pend = 1'b0; b_cnt++; end

      axi.awready = (aw_stall == 0);
      if (axi.awvalid && axi.awready) begin
        exp_a = (aw_q.size() > 0) ? aw_q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (axi.awaddr !== exp_a || {axi.awlen, axi.awsize, axi.awburst} !== {8'd15, 3'b100, 2'b01} ||
            {axi.awid, axi.awlock, axi.awcache, axi.awprot, axi.awqos} !== '0) begin
          n_fail++; $display("FAIL aw_beat: addr=%h len=%0d size=%0d burst=%0d, required addr=%h len=15 size=4 burst=1", axi.awaddr, axi.awlen, axi.awsize, axi.awburst, exp_a);
        end
        w_addr = axi.awaddr; aw_cnt++;
        aw_stall = stall_en ? $urandom_range(0, 7) : 0;
      end else if (aw_stall > 0) aw_stall--;
      p_awv = axi.awvalid && !axi.awready; p_awaddr = axi.awaddr;

      axi.wready = (w_stall == 0);
      if (axi.wvalid && axi.wready) begin
        n_checks++;
        if (w_q.size() == 0) begin
          n_fail++; $display("FAIL w_beat: unexpected beat data=%h, required none", axi.wdata);
        end else begin
          we = w_q.pop_front();
          if (axi.wdata !== we.data || w_addr !== we.addr || axi.wlast !== ((w_cnt % 16) == 15) || axi.wstrb !== '1) begin
            n_fail++; $display("FAIL w_beat: addr=%h data=%h last=%0b, required addr=%h data=%h last=%0b", w_addr, axi.wdata, axi.wlast, we.addr, we.data, ((w_cnt % 16) == 15));
          end
        end
        if (w_cnt == 0) first_w = axi.wdata;
        mem[w_addr] = axi.wdata;
        w_addr = w_addr + 32'd16;
        if (axi.wlast) begin
          b_pend = 1'b1;
          b_resp_pend = ((w_cnt / 16) == err_burst) ? 2'b10 : 2'b00;
        end
        w_cnt++;
        w_stall = stall_en ? $urandom_range(0, 7) : 0;
      end else if (w_stall > 0) w_stall--;
      p_wv = axi.wvalid && !axi.wready; p_wdata = axi.wdata; p_wlast = axi.wlast;

      // read data: handled before AR so the first beat trails the AR handshake
      if (r_act) begin
        ra = r_addr + 32'(16 * r_beat);
        rd = mem.exists(ra) ? mem[ra] : '0;
        if (ra == corrupt_addr) rd[0] = ~rd[0];
        axi.rvalid = 1'b1; axi.rdata = rd; axi.rresp = 2'b00; axi.rlast = (r_beat == 15);
        if (axi.rready) begin
          r_cnt++; r_beat++;
          if (r_beat == 16) r_act = 1'b0;
        end
      end else begin
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
      end

      axi.arready = (ar_stall == 0);
      if (axi.arvalid && axi.arready) begin
        exp_a = (ar_q.size() > 0) ? ar_q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (axi.araddr !== exp_a || {axi.arlen, axi.arsize, axi.arburst} !== {8'd15, 3'b100, 2'b01} ||
            {axi.arid, axi.arlock, axi.arcache, axi.arprot, axi.arqos} !== '0) begin
          n_fail++; $display("FAIL ar_beat: addr=%h len=%0d size=%0d, required addr=%h len=15 size=4", axi.araddr, axi.arlen, axi.arsize, exp_a);
        end
        r_addr = axi.araddr; r_beat = 0; r_act = 1'b1; ar_cnt++;
        ar_stall = stall_en ? $urandom_range(0, 7) : 0;
      end else if (ar_stall > 0) ar_stall--;
      p_arv = axi.arvalid && !axi.arready; p_araddr = axi.araddr;
    end
  end

  // Configure the slave and load the scoreboard with the expected AW/W/AR traffic of one pass.
  task automatic setup_pass(input logic [31:0] corrupt, input int eburst, input bit stall);
    logic [31:0] a;
    corrupt_addr = corrupt; err_burst = eburst; stall_en = stall;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    w_q.delete(); aw_q.delete(); ar_q.delete();
    for (int n = 0; n < NB; n++) begin
      a = BASE + 32'(256 * n);
      aw_q.push_back(a);
      ar_q.push_back(a);
      for (int k = 0; k < 16; k++) w_q.push_back('{a + 32'(16 * k), exp_data(a + 32'(16 * k))});
    end
  endtask

  task automatic pulse_start();
    @(posedge mig_clk); #1 start = 1'b1;
    @(posedge mig_clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge mig_clk); #1;
      if (done) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL done_timeout: done=%0b after 4000 cycles, required 1", done); end
  endtask

  task automatic test_reset();
    mig_rst = 1'b1; init_calib_complete = 1'b1; start = 1'b0;
    repeat (3) @(posedge mig_clk);
    #1;
    n_checks++;
    if ({busy, done, pass, error_count, first_err_addr} !== '0) begin
      n_fail++; $display("FAIL reset_status: busy=%0b done=%0b pass=%0b err=%0d first=%h, required all 0", busy, done, pass, error_count, first_err_addr);
    end
    n_checks++;
    if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_bus: aw/w/ar/b/r=%b, required 00000", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready});
    end
    mig_rst = 1'b0;
  endtask

  task automatic test_ideal();
    setup_pass(32'hFFFF_FFF0, -1, 1'b0);
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || axi.awvalid !== 1'b1) begin
      n_fail++; $display("FAIL start_latency: busy=%0b awvalid=%0b, required 1 1", busy, axi.awvalid);
    end
    wait_done();
    n_checks++;
    if ({aw_cnt, w_cnt, ar_cnt, r_cnt, b_cnt} !== {32'd4, 32'd64, 32'd4, 32'd64, 32'd4}) begin
      n_fail++; $display("FAIL ideal_counts: aw=%0d w=%0d ar=%0d r=%0d b=%0d, required 4 64 4 64 4", aw_cnt, w_cnt, ar_cnt, r_cnt, b_cnt);
    end
    n_checks++;
    if (busy !== 1'b0 || pass !== 1'b1 || error_count !== 16'd0) begin
      n_fail++; $display("FAIL ideal_result: busy=%0b pass=%0b err=%0d, required 0 1 0", busy, pass, error_count);
    end
    n_checks++;
    if (first_w !== FIRST_BEAT) begin
      n_fail++; $display("FAIL first_wbeat: %h, required %h", first_w, FIRST_BEAT);
    end
    n_checks++;
    if (w_q.size() != 0 || aw_q.size() != 0 || ar_q.size() != 0) begin
      n_fail++; $display("FAIL ideal_scoreboard: left w=%0d aw=%0d ar=%0d, required 0 0 0", w_q.size(), aw_q.size(), ar_q.size());
    end
    repeat (3) @(posedge mig_clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL done_sticky: done=%0b pass=%0b busy=%0b, required 1 1 0", done, pass, busy);
    end
  endtask

  task automatic test_corrupt();
    setup_pass(32'h0000_0120, -1, 1'b0);
    pulse_start();
    wait_done();
    n_checks++;
    if (error_count !== 16'd1 || first_err_addr !== 32'h0000_0120 || pass !== 1'b0) begin
      n_fail++; $display("FAIL corrupt_result: err=%0d first=%h pass=%0b, required 1 00000120 0", error_count, first_err_addr, pass);
    end
  endtask

  task automatic test_stall();
    setup_pass(32'hFFFF_FFF0, -1, 1'b1);
    pulse_start();
    n_checks++;
    if (done !== 1'b0 || error_count !== 16'd0 || first_err_addr !== 32'd0) begin
      n_fail++; $display("FAIL start_clears: done=%0b err=%0d first=%h, required 0 0 0", done, error_count, first_err_addr);
    end
    wait_done();
    n_checks++;
    if ({aw_cnt, w_cnt, ar_cnt, r_cnt} !== {32'd4, 32'd64, 32'd4, 32'd64} || pass !== 1'b1 || error_count !== 16'd0) begin
      n_fail++; $display("FAIL stall_result: aw=%0d w=%0d ar=%0d r=%0d pass=%0b err=%0d, required 4 64 4 64 1 0", aw_cnt, w_cnt, ar_cnt, r_cnt, pass, error_count);
    end
    stall_en = 1'b0;
  endtask

  task automatic test_bresp();
    setup_pass(32'hFFFF_FFF0, 2, 1'b0);
    pulse_start();
    wait_done();
    n_checks++;
    if (error_count !== 16'd1 || first_err_addr !== 32'h0000_0200 || pass !== 1'b0) begin
      n_fail++; $display("FAIL bresp_result: err=%0d first=%h pass=%0b, required 1 00000200 0", error_count, first_err_addr, pass);
    end
    err_burst = -1;
  endtask

  task automatic test_start_ignore();
    init_calib_complete = 1'b0;
    pulse_start();
    repeat (3) @(posedge mig_clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || axi.awvalid !== 1'b0 || done !== 1'b1 || error_count !== 16'd1) begin
      n_fail++; $display("FAIL nocalib_start: busy=%0b awvalid=%0b done=%0b err=%0d, required 0 0 1 1", busy, axi.awvalid, done, error_count);
    end
    init_calib_complete = 1'b1;
    setup_pass(32'hFFFF_FFF0, -1, 1'b0);
    pulse_start();
    repeat (20) @(posedge mig_clk);
    pulse_start();
    wait_done();
    n_checks++;
    if (aw_cnt != 4 || w_cnt != 64 || pass !== 1'b1 || w_q.size() != 0) begin
      n_fail++; $display("FAIL busy_restart: aw=%0d w=%0d pass=%0b wq=%0d, required 4 64 1 0", aw_cnt, w_cnt, pass, w_q.size());
    end
  endtask

  task automatic test_rst_mid();
    bit hit;
    setup_pass(32'hFFFF_FFF0, -1, 1'b0);
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge mig_clk); #1;
      if (w_cnt == 7) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL rst_wait_beat7: w_cnt=%0d, required 7", w_cnt); end
    mig_rst = 1'b1;
    @(posedge mig_clk); #1;
    n_checks++;
    if ({axi.awvalid, axi.wvalid, axi.arvalid, busy, done} !== 5'b0) begin
      n_fail++; $display("FAIL rst_mid: aw/w/ar/busy/done=%b, required 00000", {axi.awvalid, axi.wvalid, axi.arvalid, busy, done});
    end
    mig_rst = 1'b0;
    setup_pass(32'hFFFF_FFF0, -1, 1'b0);
    pulse_start();
    wait_done();
    n_checks++;
    if (pass !== 1'b1 || error_count !== 16'd0 || aw_cnt != 4 || r_cnt != 64) begin
      n_fail++; $display("FAIL rst_rerun: pass=%0b err=%0d aw=%0d r=%0d, required 1 0 4 64", pass, error_count, aw_cnt, r_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_corrupt();
    test_stall();
    test_bresp();
    test_start_ignore();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
